// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: synchronises SCK/CS_N/MOSI into sys_clk, deserialises
// MOSI bytes for the command core and serialises tx bytes onto MISO, MSB first.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int RDY_CYCLES  = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TMR_W = $clog2(RDY_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RDY_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sck_ff, cs_ff, mosi_ff;
    logic                   sck_d, cs_d;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;

    logic sck_sync, cs_n_sync, mosi_sync;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_sync  = sck_ff[SYNC_STAGES-1];
    assign cs_n_sync = cs_ff[SYNC_STAGES-1];
    assign mosi_sync = mosi_ff[SYNC_STAGES-1];

    assign sck_rise = sck_sync & ~sck_d;
    assign sck_fall = ~sck_sync & sck_d;
    assign cs_rise  = cs_n_sync & ~cs_d;
    // NOTE: the CS synchroniser is preset high, so a CS_N already low at reset exit
    // looks like a fall; armed only opens once a genuine high level has been seen.
    assign cs_fall  = ~cs_n_sync & cs_d & armed;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            sck_ff  <= '0;
            cs_ff   <= '1;
            mosi_ff <= '0;
            sck_d   <= 1'b0;
            cs_d    <= 1'b1;
            fill    <= '0;
            armed   <= 1'b0;
        end else begin
            sck_ff  <= {sck_ff[SYNC_STAGES-2:0], spi_sck};
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], spi_cs_n};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
            sck_d   <= sck_sync;
            cs_d    <= cs_n_sync;
            fill    <= {fill[SYNC_STAGES-1:0], 1'b1};
            armed   <= armed | (fill[SYNC_STAGES] & cs_n_sync);
        end
    end

    state_t          state;
    logic [7:0]      tx_hold, shift_tx, shift_rx;
    logic [7:0]      tx_reload;
    logic [2:0]      bit_cnt;
    logic [TMR_W-1:0] tmr;

    // A load strobe coinciding with a reload is forwarded straight into the shifter.
    assign tx_reload = tx_load ? tx_data : tx_hold;
    assign spi_miso  = spi_miso_oe & shift_tx[7];

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= IDLE;
            tx_hold     <= '0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            bit_cnt     <= '0;
            tmr         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (tx_load)
                tx_hold <= tx_data;
            if (tmr != '0) begin
                tmr      <= tmr - TMR_ONE;
                rx_valid <= (tmr != TMR_ONE);
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= SHIFT;
                        bit_cnt     <= '0;
                        shift_tx    <= tx_reload;
                        spi_miso_oe <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        spi_miso_oe <= 1'b0;
                        bit_cnt     <= '0;
                        frame_err   <= (bit_cnt != 3'd0);
                    end else if (!cs_n_sync) begin
                        if (sck_rise) begin
                            shift_rx <= {shift_rx[6:0], mosi_sync};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift_rx[6:0], mosi_sync};
                                rx_valid <= 1'b1;
                                tmr      <= TMR_LOAD;
                                overrun  <= (tmr != '0);
                            end
                        end
                        if (sck_fall) begin
                            if (bit_cnt == 3'd0)
                                shift_tx <= tx_reload;
                            else
                                shift_tx <= {shift_tx[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a default instance plus a long-valid instance that
// shares the same SPI pins for the overrun case.
module tb_spi_slave_if;

    localparam int SS    = 2;
    localparam int RDY   = 2;
    // One byte at the fastest legal SCK spans 48 sys_clk cycles, so 60 keeps the timer live.
    localparam int RDY_B = 60;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;

    logic       miso_a, oe_a, rx_valid_a, frame_err_a, overrun_a;
    logic [7:0] rx_data_a;
    logic       miso_b, oe_b, rx_valid_b, frame_err_b, overrun_b;
    logic [7:0] rx_data_b;

    always #5 sys_clk = ~sys_clk;

    spi_slave_if #(.SYNC_STAGES(SS), .RDY_CYCLES(RDY)) u_dut (
        .sys_clk(sys_clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_a), .spi_miso_oe(oe_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data),
        .tx_load(tx_load), .frame_err(frame_err_a), .overrun(overrun_a)
    );

    spi_slave_if #(.SYNC_STAGES(SS), .RDY_CYCLES(RDY_B)) u_dut_long (
        .sys_clk(sys_clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_b), .spi_miso_oe(oe_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data),
        .tx_load(tx_load), .frame_err(frame_err_b), .overrun(overrun_b)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Event monitor sampled on the falling sys_clk edge.
    bit         mon_en = 1'b0;
    int         rise_a = 0, hi_a = 0, ferr_a = 0, ovr_a = 0;
    int         rise_b = 0, ovr_b = 0;
    logic       pv_a = 1'b0, pv_b = 1'b0;
    logic [7:0] rx_log[$];

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (rx_valid_a === 1'b1 && pv_a !== 1'b1) begin
                rise_a++;
                rx_log.push_back(rx_data_a);
            end
            if (rx_valid_a === 1'b1) hi_a++;
            if (frame_err_a === 1'b1) ferr_a++;
            if (overrun_a === 1'b1) ovr_a++;
            if (rx_valid_b === 1'b1 && pv_b !== 1'b1) rise_b++;
            if (overrun_b === 1'b1) ovr_b++;
        end
        pv_a = rx_valid_a;
        pv_b = rx_valid_b;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        @(negedge sys_clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge sys_clk);
        tx_load = 1'b0;
    endtask

    task automatic cs_assert();
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic cs_release(input int h);
        cyc(h);
        spi_cs_n = 1'b1;
        cyc(10);
    endtask

    // Shifts nbits MSB-first with half-period h; optionally pulses tx_load during the
    // high phase of the last bit so the value lands before the next-byte reload.
    task automatic xfer(input logic [7:0] mo, input int nbits, input int h,
                        input bit ld, input logic [7:0] ldv, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            cyc(h);
            mi[i] = miso_a;
            spi_sck = 1'b1;
            if (ld && i == 0) begin
                cyc(1);
                tx_data = ldv;
                tx_load = 1'b1;
                cyc(1);
                tx_load = 1'b0;
                cyc(h - 2);
            end else begin
                cyc(h);
            end
            spi_sck = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] m0, m1, m2;
        int r0, h0, f0, o0, rb0, ob0, n0;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81};

        // Reset held with SCK toggling.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            spi_sck = ~spi_sck;
        end
        check("reset rx_data", rx_data_a, 8'h00);
        check("reset rx_valid", rx_valid_a, 1'b0);
        check("reset miso", miso_a, 1'b0);
        check("reset miso_oe", oe_a, 1'b0);
        check("reset frame_err", frame_err_a, 1'b0);
        check("reset overrun", overrun_a, 1'b0);
        check("reset rx_valid long", rx_valid_b, 1'b0);
        spi_sck = 1'b0;
        cyc(1);
        rst = 1'b1;
        mon_en = 1'b1;
        cyc(10);
        check("post-reset no rx_valid", rise_a, 0);

        // Single-byte frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            load_tx(vecs[i].tx);
            r0 = rise_a; h0 = hi_a; f0 = ferr_a;
            cs_assert();
            xfer(vecs[i].mosi, 8, 4, 1'b0, 8'h00, m0);
            cs_release(4);
            check($sformatf("vec%0d rx_data", i), rx_data_a, vecs[i].exp_rx);
            check($sformatf("vec%0d miso", i), m0, vecs[i].exp_miso);
            check($sformatf("vec%0d rx_valid pulses", i), rise_a - r0, 1);
            check($sformatf("vec%0d rx_valid width", i), hi_a - h0, RDY);
            check($sformatf("vec%0d frame_err", i), ferr_a - f0, 0);
            check($sformatf("vec%0d miso_oe idle", i), oe_a, 1'b0);
        end

        // Three-byte frame, new tx byte loaded while byte 1 finishes.
        load_tx(8'hC3);
        r0 = rise_a; n0 = rx_log.size();
        cs_assert();
        xfer(8'h81, 8, 4, 1'b1, 8'h55, m0);
        xfer(8'h12, 8, 4, 1'b0, 8'h00, m1);
        xfer(8'h34, 8, 4, 1'b0, 8'h00, m2);
        cs_release(4);
        check("3b rx_valid pulses", rise_a - r0, 3);
        if (rx_log.size() >= n0 + 3) begin
            check("3b byte0", rx_log[n0], 8'h81);
            check("3b byte1", rx_log[n0+1], 8'h12);
            check("3b byte2", rx_log[n0+2], 8'h34);
        end else begin
            check("3b log depth", rx_log.size() - n0, 3);
        end
        check("3b miso0", m0, 8'hC3);
        check("3b miso1", m1, 8'h55);
        check("3b miso2", m2, 8'h55);

        // tx_load coinciding with the frame-start reload.
        load_tx(8'h11);
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        cyc(SS);
        tx_data = 8'h99;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        cyc(6);
        xfer(8'h66, 8, 4, 1'b0, 8'h00, m0);
        cs_release(4);
        check("bypass miso", m0, 8'h99);
        check("bypass rx_data", rx_data_a, 8'h66);

        // Abort after 5 bits, then a clean byte.
        r0 = rise_a; f0 = ferr_a;
        cs_assert();
        xfer(8'hB0, 5, 4, 1'b0, 8'h00, m0);
        cs_release(4);
        check("abort frame_err", ferr_a - f0, 1);
        check("abort no rx_valid", rise_a - r0, 0);
        cs_assert();
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, m0);
        cs_release(4);
        check("after abort rx_data", rx_data_a, 8'hFF);
        check("after abort rx_valid", rise_a - r0, 1);
        check("after abort frame_err", ferr_a - f0, 1);

        // Back-to-back bytes at the fastest SCK.
        r0 = rise_a; o0 = ovr_a; rb0 = rise_b; ob0 = ovr_b;
        cs_assert();
        xfer(8'hC7, 8, SS + 1, 1'b0, 8'h00, m0);
        xfer(8'h3E, 8, SS + 1, 1'b0, 8'h00, m1);
        cs_release(SS + 1);
        check("ovr pulse", ovr_b - ob0, 1);
        check("ovr rx_data", rx_data_b, 8'h3E);
        check("ovr rx_valid continuous", rise_b - rb0, 1);
        check("ovr short-valid none", ovr_a - o0, 0);
        check("ovr short-valid pulses", rise_a - r0, 2);
        cyc(RDY_B + 10);
        check("ovr rx_valid expired", rx_valid_b, 1'b0);

        // Reset after 3 bits; CS_N held low afterwards must not start a frame.
        cs_assert();
        xfer(8'hE0, 3, 4, 1'b0, 8'h00, m0);
        @(negedge sys_clk);
        rst = 1'b0;
        cyc(2);
        check("midrst miso_oe", oe_a, 1'b0);
        check("midrst rx_valid", rx_valid_a, 1'b0);
        rst = 1'b1;
        r0 = rise_a; f0 = ferr_a;
        cyc(10);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, m0);
        check("held-low no frame", rise_a - r0, 0);
        check("held-low miso_oe", oe_a, 1'b0);
        cs_release(1);
        cs_assert();
        xfer(8'h0F, 8, 4, 1'b0, 8'h00, m0);
        cs_release(4);
        check("midrst rx_data", rx_data_a, 8'h0F);
        check("midrst rx_valid pulses", rise_a - r0, 1);
        check("midrst frame_err", ferr_a - f0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
